// File: rtl/env_seq_mem.sv
// Envelope sample RAM with a playback sequencer that streams a contiguous window to the modulator.
// Define ENV_SEQ_LOOP_EN to add the loop_en input for continuous looped playback.
module env_seq_mem #(
  parameter int AMP_W  = 14,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [AMP_W-1:0]  wr_data,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              abort,
`ifdef ENV_SEQ_LOOP_EN
  input  logic              loop_en,
`endif
  output logic              sample_valid,
  output logic [AMP_W-1:0]  sample_data,
  output logic              sample_last,
  output logic              done,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               valid_q, last_q;
  logic [AMP_W-1:0]   data_q;
  logic [AMP_W-1:0]   ram_q;
  logic               rd_en;
  logic [AMP_W-1:0]   mem [DEPTH];

`ifdef ENV_SEQ_LOOP_EN
  logic               loop_q, loop_d;
  logic [ADDR_W-1:0]  base_addr_q, base_addr_d;
  logic [LEN_W-1:0]   base_len_q, base_len_d;
`endif

  // Read-first block RAM: the read sees the word as it was before a same-edge write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) ram_q <= mem[addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
`ifdef ENV_SEQ_LOOP_EN
      loop_q      <= 1'b0;
      base_addr_q <= '0;
      base_len_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      valid_q <= rd_en;
      last_q  <= rd_en && (rem_q == LEN_W'(1));
      data_q  <= sample_data;
`ifdef ENV_SEQ_LOOP_EN
      loop_q      <= loop_d;
      base_addr_q <= base_addr_d;
      base_len_q  <= base_len_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
`ifdef ENV_SEQ_LOOP_EN
    loop_d      = loop_q;
    base_addr_d = base_addr_q;
    base_len_d  = base_len_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          addr_d  = start_addr;
          rem_d   = start_len;
          state_d = (start_len == '0) ? FLUSH : RUN;
`ifdef ENV_SEQ_LOOP_EN
          loop_d      = loop_en;
          base_addr_d = start_addr;
          base_len_d  = start_len;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
`ifdef ENV_SEQ_LOOP_EN
            if (loop_q) begin
              addr_d = base_addr_q;
              rem_d  = base_len_q;
            end else begin
              state_d = FLUSH;
            end
`else
            state_d = FLUSH;
`endif
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An abort on the last RUN cycle suppresses the read so nothing reaches the output.
  always_comb begin
    rd_en        = (state_q == RUN) && !abort;
    start_ready  = (state_q == IDLE);
    busy         = (state_q != IDLE);
    done         = (state_q == FLUSH);
    sample_valid = valid_q;
    sample_last  = last_q;
    sample_data  = valid_q ? ram_q : data_q;
  end

endmodule
